dr_sync_sink: RTL and testbench

//  Clocked consumer at the output end of the dual-rail, 4-phase asynchronous pipeline.
//  - Samples WIDTH dual-rail bits through synchronisers.
//  - Detects a complete DATA token, captures it into a one-word buffer and raises the ack.
//  - Waits for the NULL spacer, then drops the ack.
//  - Presents captured words to synchronous logic with a valid/ready handshake.

---
 rtl/dr_sync_sink.sv | 101 ++++++++++
 tb/tb_dr_sync_sink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dr_sync_sink.sv
// Clocked sink for a dual-rail 4-phase asynchronous pipeline. It synchronises the rails,
// captures complete tokens into a one-word buffer, acks them, and drains via valid/ready.
module dr_sync_sink #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] data_in,
  output logic               ack_next,
  output logic [WIDTH-1:0]   word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               err
);

  // state     | meaning
  // WAIT_DATA | ack low, waiting for a complete, stable, legal token and a free buffer
  // WAIT_NULL | ack high, token captured, waiting for an all-NULL stable spacer
  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [2*WIDTH-1:0] s;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   s_true;
  logic               complete, is_null, illegal, stable;
  logic               buffer_free, capture;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      p_q <= s;
    end
  end

  always_comb begin
    complete = 1'b1;
    is_null  = 1'b1;
    illegal  = 1'b0;
    s_true   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_true[i] = s[2*i+1];
      if (s[2*i+1] && s[2*i]) illegal = 1'b1;
      if (s[2*i+1] == s[2*i]) complete = 1'b0;
      if (s[2*i+1] || s[2*i]) is_null = 1'b0;
    end
    stable = (s == p_q);
  end

  // A drain on the same edge as a capture frees the slot the capture fills.
  assign buffer_free = !word_valid || word_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (complete && stable && !illegal && buffer_free) begin
          capture = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (is_null && stable) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_DATA;
    else        state_q <= state_d;
  end

  assign ack_next = (state_q == WAIT_NULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (capture) begin
        word_out   <= s_true;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dr_sync_sink.sv
// Scoreboard bench for dr_sync_sink: an emulated async stage issues tokens, a monitor
// checks every drained word against the queue of words that were sent.
module tb_dr_sync_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        ack_next;
  logic [7:0]  word_out;
  logic        word_valid;
  logic        word_ready;
  logic        err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  logic        ready_mode = 1'b0;
  logic        ready_force = 1'b1;

  dr_sync_sink #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .ack_next   (ack_next),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [7:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input logic level, input int budget, output int edges);
    edges = 0;
    while (ack_next !== level && edges < budget) begin
      tick();
      edges++;
    end
    if (ack_next !== level) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: ack_next=%b expected %b after %0d edges", ack_next, level, edges);
    end
  endtask

  task automatic send(input logic [7:0] w);
    int e;
    exp_q.push_back(w);
    data_in = enc(w);
    wait_ack(1'b1, 300, e);
    data_in = '0;
    wait_ack(1'b0, 300, e);
  endtask

  // word_ready only changes just after a rising edge so the negedge monitor sees what the DUT sees
  initial begin
    word_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      word_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", word_out);
        end else begin
          check("word", 32'(word_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int e;
    logic [7:0]  w;
    logic [15:0] tok;

    rst_n   = 1'b0;
    data_in = '0;
    repeat (3) tick();
    check("rst_ack", 32'(ack_next), 32'(0));
    check("rst_valid", 32'(word_valid), 32'(0));
    check("rst_word", 32'(word_out), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: single transfer with latency checks
    exp_q.push_back(8'hA5);
    data_in = enc(8'hA5);
    wait_ack(1'b1, 50, e);
    check("t1_rise_edges", 32'(e), 32'(4));
    check("t1_word", 32'(word_out), 32'hA5);
    check("t1_valid", 32'(word_valid), 32'(1));
    data_in = '0;
    wait_ack(1'b0, 50, e);
    check("t1_fall_edges", 32'(e), 32'(4));
    repeat (3) tick();

    // T2: backpressure
    ready_force = 1'b0;
    repeat (2) tick();
    send(8'h11);
    exp_q.push_back(8'h22);
    data_in = enc(8'h22);
    repeat (12) tick();
    check("t2_no_ack", 32'(ack_next), 32'(0));
    check("t2_held_valid", 32'(word_valid), 32'(1));
    check("t2_held_word", 32'(word_out), 32'h11);
    ready_force = 1'b1;
    wait_ack(1'b1, 50, e);
    check("t2_second_word", 32'(word_out), 32'h22);
    data_in = '0;
    wait_ack(1'b0, 50, e);
    repeat (3) tick();

    // T3: token present across reset release
    rst_n   = 1'b0;
    data_in = 16'hAAAA;
    repeat (2) tick();
    exp_q.push_back(8'hFF);
    rst_n = 1'b1;
    wait_ack(1'b1, 50, e);
    check("t3_word", 32'(word_out), 32'hFF);
    check("t3_err", 32'(err), 32'(0));
    data_in = '0;
    wait_ack(1'b0, 50, e);
    repeat (3) tick();

    // T4: rails arrive one bit per cycle
    w = 8'($urandom);
    exp_q.push_back(w);
    data_in = '0;
    for (int i = 0; i < 8; i++) begin
      data_in[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
      tick();
      if (i < 7) check("t4_no_early_ack", 32'(ack_next), 32'(0));
    end
    wait_ack(1'b1, 50, e);
    check("t4_word", 32'(word_out), 32'(w));
    data_in = '0;
    wait_ack(1'b0, 50, e);
    repeat (3) tick();

    // T5: illegal pair on bit 3, then a valid token
    tok = enc(8'h0F);
    data_in = tok;
    data_in[7:6] = 2'b11;
    repeat (3) begin
      tick();
      check("t5_no_ack_fault", 32'(ack_next), 32'(0));
    end
    data_in = tok;
    repeat (2) tick();
    check("t5_err_set", 32'(err), 32'(1));
    check("t5_no_ack_yet", 32'(ack_next), 32'(0));
    exp_q.push_back(8'h0F);
    wait_ack(1'b1, 50, e);
    check("t5_word", 32'(word_out), 32'h0F);
    data_in = '0;
    wait_ack(1'b0, 50, e);
    check("t5_err_sticky", 32'(err), 32'(1));
    repeat (3) tick();

    // T6: reset while in WAIT_NULL holding a word
    ready_force = 1'b0;
    repeat (2) tick();
    exp_q.push_back(8'h3C);
    data_in = enc(8'h3C);
    wait_ack(1'b1, 50, e);
    check("t6_pre_valid", 32'(word_valid), 32'(1));
    rst_n = 1'b0;
    tick();
    check("t6_ack", 32'(ack_next), 32'(0));
    check("t6_valid", 32'(word_valid), 32'(0));
    check("t6_word", 32'(word_out), 32'(0));
    check("t6_err", 32'(err), 32'(0));
    exp_q.delete();
    data_in = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_post_ack", 32'(ack_next), 32'(0));

    // random traffic with random backpressure
    ready_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
